// File: rtl/fifo_flex_if.sv
// fifo_flex_if: producer/consumer signal bundle for fifo_flex
interface fifo_flex_if #(
  parameter int WIDTH    = 8,
  parameter int LOG_SIZE = 5
);
  logic                clr;
  logic [WIDTH-1:0]    wdata;
  logic                wen;
  logic                ren;
  logic [WIDTH-1:0]    rdata;
  logic                rvalid;
  logic                empty;
  logic                full;
  logic                almost_empty;
  logic                almost_full;
  logic [LOG_SIZE:0]   count;
  logic                overflow;
  logic                underflow;
  modport master (
    output clr, wdata, wen, ren,
    input  rdata, rvalid, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
  modport slave (
    input  clr, wdata, wen, ren,
    output rdata, rvalid, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_flex.sv
// fifo_flex: synchronous FIFO with optional first-word-fall-through, occupancy and threshold flags
module fifo_flex #(
  parameter int WIDTH     = 8,
  parameter int LOG_SIZE  = 5,
  parameter bit FWFT      = 1'b0,
  parameter int AFULL_TH  = (1 << LOG_SIZE) - 4,
  parameter int AEMPTY_TH = 4
) (
  input logic        clk,
  input logic        rst_n,
  fifo_flex_if.slave bus
);
  localparam int SIZE = 1 << LOG_SIZE;
  localparam int CW   = LOG_SIZE + 1;
  localparam logic [CW-1:0] C_FULL = CW'(SIZE);
  localparam logic [CW-1:0] C_AE   = CW'(AEMPTY_TH);
  localparam logic [CW-1:0] C_AF   = CW'(AFULL_TH);
  if (AEMPTY_TH < 0 || AEMPTY_TH >= AFULL_TH || AFULL_TH > SIZE) begin : g_bad_th
    $error("fifo_flex: thresholds must satisfy 0 <= AEMPTY_TH < AFULL_TH <= SIZE");
  end
  logic [WIDTH-1:0]    r_mem [SIZE];
  logic [LOG_SIZE-1:0] r_head;
  logic [LOG_SIZE-1:0] r_tail;
  logic [CW-1:0]       r_count;
  logic                r_empty;
  logic                r_full;
  logic                r_ae;
  logic                r_af;
  logic                r_ovf;
  logic                r_udf;
  logic                r_rvalid;
  logic                r_rd_pend;
  logic [WIDTH-1:0]    r_rd_word;
  logic [WIDTH-1:0]    r_rdata;
  logic                w_rd_ok;
  logic                w_wr_ok;
  logic [CW-1:0]       w_count_nxt;
  logic [LOG_SIZE-1:0] w_head_nxt;
  logic [LOG_SIZE-1:0] w_tail_nxt;
  logic [WIDTH-1:0]    w_head_word;
  logic [WIDTH-1:0]    w_fw_word;
  // accept decisions, next occupancy/pointers, and the word that will sit at the head next cycle
  always_comb begin
    w_rd_ok     = bus.ren & ~r_empty;
    w_wr_ok     = bus.wen & (~r_full | w_rd_ok);
    w_count_nxt = r_count + CW'(w_wr_ok) - CW'(w_rd_ok);
    w_head_nxt  = r_head + LOG_SIZE'(w_rd_ok);
    w_tail_nxt  = r_tail + LOG_SIZE'(w_wr_ok);
    w_head_word = r_mem[r_head];
    w_fw_word   = (w_wr_ok && w_head_nxt == r_tail) ? bus.wdata : r_mem[w_head_nxt];
  end
  // storage array written at the tail; contents survive reset and flush
  always_ff @(posedge clk)
    if (w_wr_ok && !bus.clr) r_mem[r_tail] <= bus.wdata;
  // pointers, occupancy and registered status flags; flush overrides any request
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ae    <= 1'b1;
      r_af    <= 1'b0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else if (bus.clr) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ae    <= 1'b1;
      r_af    <= 1'b0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
      r_empty <= w_count_nxt == '0;
      r_full  <= w_count_nxt == C_FULL;
      r_ae    <= w_count_nxt <= C_AE;
      r_af    <= w_count_nxt >= C_AF;
      r_ovf   <= bus.wen & ~w_wr_ok;
      r_udf   <= bus.ren & ~w_rd_ok;
    end
  // read port: standard mode captures the old head word at accept and presents it one edge later;
  // FWFT mode keeps the next head word (bypassing wdata into an emptying FIFO) registered at all times
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rd_pend <= 1'b0;
      r_rd_word <= '0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else if (bus.clr) begin
      r_rd_pend <= 1'b0;
      r_rvalid  <= 1'b0;
    end else begin
      r_rd_pend <= w_rd_ok;
      if (w_rd_ok) r_rd_word <= w_head_word;
      if (FWFT) begin
        r_rvalid <= w_count_nxt != '0;
        if (w_count_nxt != '0) r_rdata <= w_fw_word;
      end else begin
        r_rvalid <= r_rd_pend;
        if (r_rd_pend) r_rdata <= r_rd_word;
      end
    end
  assign bus.rdata        = r_rdata;
  assign bus.rvalid       = r_rvalid;
  assign bus.empty        = r_empty;
  assign bus.full         = r_full;
  assign bus.almost_empty = r_ae;
  assign bus.almost_full  = r_af;
  assign bus.count        = r_count;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_udf;
endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: scoreboard bench for fifo_flex in standard (u0) and FWFT (u1) modes
module tb_fifo_flex;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vecs = 0;
  int errs = 0;
  int m0 = 0;
  int m1 = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  fifo_flex_if #(.WIDTH(8), .LOG_SIZE(5)) if0 ();
  fifo_flex_if #(.WIDTH(8), .LOG_SIZE(5)) if1 ();
  fifo_flex #(.WIDTH(8), .LOG_SIZE(5), .FWFT(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  fifo_flex #(.WIDTH(8), .LOG_SIZE(5), .FWFT(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  always #5 clk = ~clk;
  // standard-mode scoreboard: push accepted writes, pop on every rvalid pulse
  always @(negedge clk) begin : mon0
    logic rd, wr;
    logic [7:0] e;
    if (!rst_n) begin
      m0 = 0;
      q0.delete();
    end else begin
      if (if0.rvalid) begin
        vecs++;
        if (q0.size() == 0) begin
          errs++;
          $display("FAIL std_rvalid_unexpected: rvalid=1 rdata=%02h with nothing outstanding", if0.rdata);
        end else begin
          e = q0.pop_front();
          if (if0.rdata !== e) begin
            errs++;
            $display("FAIL std_data: rdata=%02h expected %02h", if0.rdata, e);
          end
        end
      end
      if (if0.clr) begin
        m0 = 0;
        q0.delete();
      end else begin
        rd = if0.ren && m0 != 0;
        wr = if0.wen && (m0 != 32 || rd);
        if (wr) q0.push_back(if0.wdata);
        m0 = m0 + int'(wr) - int'(rd);
      end
    end
  end
  // FWFT scoreboard: the presented word is compared whenever a pop is accepted
  always @(negedge clk) begin : mon1
    logic rd, wr;
    logic [7:0] e;
    if (!rst_n) begin
      m1 = 0;
      q1.delete();
    end else if (if1.clr) begin
      m1 = 0;
      q1.delete();
    end else begin
      rd = if1.ren && m1 != 0;
      wr = if1.wen && (m1 != 32 || rd);
      if (rd) begin
        vecs++;
        e = q1.pop_front();
        if (if1.rdata !== e) begin
          errs++;
          $display("FAIL fwft_data: rdata=%02h expected %02h", if1.rdata, e);
        end
      end
      if (wr) q1.push_back(if1.wdata);
      m1 = m1 + int'(wr) - int'(rd);
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    if0.clr = 1'b0; if0.wen = 1'b0; if0.ren = 1'b0; if0.wdata = 8'h00;
    if1.clr = 1'b0; if1.wen = 1'b0; if1.ren = 1'b0; if1.wdata = 8'h00;
  endtask
  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    vecs++; if (if0.count !== 6'd0) begin errs++; $display("FAIL rst_count: got %0d want 0", if0.count); end
    vecs++; if (if0.empty !== 1'b1) begin errs++; $display("FAIL rst_empty: got %b want 1", if0.empty); end
    vecs++; if (if0.full !== 1'b0) begin errs++; $display("FAIL rst_full: got %b want 0", if0.full); end
    vecs++; if (if0.almost_empty !== 1'b1) begin errs++; $display("FAIL rst_aempty: got %b want 1", if0.almost_empty); end
    vecs++; if (if0.almost_full !== 1'b0) begin errs++; $display("FAIL rst_afull: got %b want 0", if0.almost_full); end
    vecs++; if (if0.rdata !== 8'h00) begin errs++; $display("FAIL rst_rdata: got %02h want 00", if0.rdata); end
    vecs++; if (if0.rvalid !== 1'b0) begin errs++; $display("FAIL rst_rvalid: got %b want 0", if0.rvalid); end
    vecs++; if (if0.overflow !== 1'b0) begin errs++; $display("FAIL rst_ovf: got %b want 0", if0.overflow); end
    vecs++; if (if0.underflow !== 1'b0) begin errs++; $display("FAIL rst_udf: got %b want 0", if0.underflow); end
    vecs++; if (if1.rvalid !== 1'b0) begin errs++; $display("FAIL rst_fwft_rvalid: got %b want 0", if1.rvalid); end
    vecs++; if (if1.rdata !== 8'h00) begin errs++; $display("FAIL rst_fwft_rdata: got %02h want 00", if1.rdata); end
  endtask
  task automatic test_fill_overflow();
    for (int i = 1; i <= 32; i++) begin
      if0.wen = 1'b1; if0.wdata = 8'(i);
      cyc();
      vecs++; if (if0.count !== 6'(i)) begin errs++; $display("FAIL fill_count: got %0d want %0d", if0.count, i); end
      vecs++; if (if0.almost_empty !== (i <= 4)) begin errs++; $display("FAIL fill_aempty at %0d: got %b", i, if0.almost_empty); end
      vecs++; if (if0.almost_full !== (i >= 28)) begin errs++; $display("FAIL fill_afull at %0d: got %b", i, if0.almost_full); end
      vecs++; if (if0.full !== (i == 32)) begin errs++; $display("FAIL fill_full at %0d: got %b", i, if0.full); end
    end
    if0.wdata = 8'hEE;
    cyc();
    vecs++; if (if0.overflow !== 1'b1) begin errs++; $display("FAIL ovf_pulse: got %b want 1", if0.overflow); end
    vecs++; if (if0.count !== 6'd32) begin errs++; $display("FAIL ovf_count: got %0d want 32", if0.count); end
    if0.wen = 1'b0;
    cyc();
    vecs++; if (if0.overflow !== 1'b0) begin errs++; $display("FAIL ovf_width: got %b want 0", if0.overflow); end
    for (int i = 31; i >= 0; i--) begin
      if0.ren = 1'b1;
      cyc();
      vecs++; if (if0.count !== 6'(i)) begin errs++; $display("FAIL drain_count: got %0d want %0d", if0.count, i); end
      vecs++; if (if0.almost_full !== (i >= 28)) begin errs++; $display("FAIL drain_afull at %0d: got %b", i, if0.almost_full); end
      vecs++; if (if0.almost_empty !== (i <= 4)) begin errs++; $display("FAIL drain_aempty at %0d: got %b", i, if0.almost_empty); end
      vecs++; if (if0.empty !== (i == 0)) begin errs++; $display("FAIL drain_empty at %0d: got %b", i, if0.empty); end
    end
    if0.ren = 1'b0;
    repeat (3) cyc();
    vecs++; if (q0.size() != 0) begin errs++; $display("FAIL drain_all: %0d words never returned, want 0", q0.size()); end
    vecs++; if (if0.rdata !== 8'h20) begin errs++; $display("FAIL drain_hold: rdata=%02h want 20", if0.rdata); end
    vecs++; if (if0.rvalid !== 1'b0) begin errs++; $display("FAIL drain_rvalid: got %b want 0", if0.rvalid); end
  endtask
  task automatic test_std_latency();
    if0.wen = 1'b1; if0.wdata = 8'hA5;
    cyc();
    if0.wen = 1'b0; if0.ren = 1'b1;
    cyc();
    vecs++; if (if0.rvalid !== 1'b0) begin errs++; $display("FAIL lat_early: rvalid=%b want 0", if0.rvalid); end
    vecs++; if (if0.empty !== 1'b1) begin errs++; $display("FAIL lat_empty1: got %b want 1", if0.empty); end
    if0.ren = 1'b0;
    cyc();
    vecs++; if (if0.rvalid !== 1'b1) begin errs++; $display("FAIL lat_rvalid: got %b want 1", if0.rvalid); end
    vecs++; if (if0.rdata !== 8'hA5) begin errs++; $display("FAIL lat_rdata: got %02h want a5", if0.rdata); end
    vecs++; if (if0.empty !== 1'b1) begin errs++; $display("FAIL lat_empty2: got %b want 1", if0.empty); end
    cyc();
    vecs++; if (if0.rvalid !== 1'b0) begin errs++; $display("FAIL lat_pulse: rvalid=%b want 0", if0.rvalid); end
    vecs++; if (if0.rdata !== 8'hA5) begin errs++; $display("FAIL lat_hold: got %02h want a5", if0.rdata); end
  endtask
  task automatic test_wrap();
    for (int i = 0; i < 32; i++) begin
      if0.wen = 1'b1; if0.wdata = 8'(8'h40 + i);
      cyc();
    end
    for (int i = 0; i < 40; i++) begin
      if0.wen = 1'b1; if0.ren = 1'b1; if0.wdata = 8'(8'h80 + i);
      cyc();
      vecs++; if (if0.full !== 1'b1) begin errs++; $display("FAIL wrap_full cycle %0d: got %b", i, if0.full); end
      vecs++; if (if0.count !== 6'd32) begin errs++; $display("FAIL wrap_count cycle %0d: got %0d want 32", i, if0.count); end
      vecs++; if (if0.overflow !== 1'b0) begin errs++; $display("FAIL wrap_ovf cycle %0d: got %b want 0", i, if0.overflow); end
    end
    if0.wen = 1'b0;
    repeat (32) cyc();
    if0.ren = 1'b0;
    repeat (3) cyc();
    vecs++; if (q0.size() != 0) begin errs++; $display("FAIL wrap_all: %0d words never returned, want 0", q0.size()); end
    vecs++; if (if0.rdata !== 8'hA7) begin errs++; $display("FAIL wrap_last: rdata=%02h want a7", if0.rdata); end
  endtask
  task automatic test_clr();
    for (int i = 0; i < 16; i++) begin
      if0.wen = 1'b1; if0.wdata = 8'(8'h60 + i);
      cyc();
    end
    if0.clr = 1'b1; if0.wen = 1'b1; if0.ren = 1'b1; if0.wdata = 8'hFF;
    cyc();
    if0.clr = 1'b0; if0.wen = 1'b0;
    vecs++; if (if0.count !== 6'd0) begin errs++; $display("FAIL clr_count: got %0d want 0", if0.count); end
    vecs++; if (if0.empty !== 1'b1) begin errs++; $display("FAIL clr_empty: got %b want 1", if0.empty); end
    vecs++; if (if0.almost_empty !== 1'b1) begin errs++; $display("FAIL clr_aempty: got %b want 1", if0.almost_empty); end
    vecs++; if (if0.overflow !== 1'b0) begin errs++; $display("FAIL clr_ovf: got %b want 0", if0.overflow); end
    vecs++; if (if0.underflow !== 1'b0) begin errs++; $display("FAIL clr_udf: got %b want 0", if0.underflow); end
    vecs++; if (if0.rvalid !== 1'b0) begin errs++; $display("FAIL clr_rvalid: got %b want 0", if0.rvalid); end
    vecs++; if (if0.rdata !== 8'hA7) begin errs++; $display("FAIL clr_rdata: got %02h want a7", if0.rdata); end
    cyc();
    vecs++; if (if0.underflow !== 1'b1) begin errs++; $display("FAIL udf_pulse: got %b want 1", if0.underflow); end
    vecs++; if (if0.count !== 6'd0) begin errs++; $display("FAIL udf_count: got %0d want 0", if0.count); end
    if0.ren = 1'b0;
    cyc();
    vecs++; if (if0.underflow !== 1'b0) begin errs++; $display("FAIL udf_width: got %b want 0", if0.underflow); end
    if0.wen = 1'b1; if0.wdata = 8'h11;
    cyc();
    if0.wen = 1'b0; if0.ren = 1'b1;
    cyc();
    if0.ren = 1'b0;
    repeat (2) cyc();
    vecs++; if (if0.rdata !== 8'h11) begin errs++; $display("FAIL clr_reuse: rdata=%02h want 11", if0.rdata); end
  endtask
  task automatic test_fwft();
    if1.wen = 1'b1; if1.wdata = 8'h3C;
    cyc();
    if1.wen = 1'b0;
    vecs++; if (if1.rvalid !== 1'b1) begin errs++; $display("FAIL fwft_rvalid: got %b want 1", if1.rvalid); end
    vecs++; if (if1.rdata !== 8'h3C) begin errs++; $display("FAIL fwft_rdata: got %02h want 3c", if1.rdata); end
    vecs++; if (if1.empty !== 1'b0) begin errs++; $display("FAIL fwft_nempty: got %b want 0", if1.empty); end
    if1.ren = 1'b1;
    cyc();
    if1.ren = 1'b0;
    vecs++; if (if1.empty !== 1'b1) begin errs++; $display("FAIL fwft_empty: got %b want 1", if1.empty); end
    vecs++; if (if1.rvalid !== 1'b0) begin errs++; $display("FAIL fwft_rvalid0: got %b want 0", if1.rvalid); end
    vecs++; if (if1.rdata !== 8'h3C) begin errs++; $display("FAIL fwft_hold: got %02h want 3c", if1.rdata); end
    if1.wen = 1'b1; if1.wdata = 8'h51;
    cyc();
    if1.wdata = 8'h52; if1.ren = 1'b1;
    cyc();
    vecs++; if (if1.rdata !== 8'h52) begin errs++; $display("FAIL fwft_bypass: got %02h want 52", if1.rdata); end
    vecs++; if (if1.count !== 6'd1) begin errs++; $display("FAIL fwft_bypass_count: got %0d want 1", if1.count); end
    if1.wen = 1'b0;
    cyc();
    cyc();
    if1.ren = 1'b0;
    vecs++; if (if1.underflow !== 1'b1) begin errs++; $display("FAIL fwft_udf: got %b want 1", if1.underflow); end
    vecs++; if (if1.empty !== 1'b1) begin errs++; $display("FAIL fwft_empty2: got %b want 1", if1.empty); end
  endtask
  task automatic test_fwft_wrap();
    for (int i = 0; i < 32; i++) begin
      if1.wen = 1'b1; if1.wdata = 8'(i);
      cyc();
      vecs++; if (if1.rdata !== 8'h00) begin errs++; $display("FAIL fwft_fill_head: got %02h want 00", if1.rdata); end
    end
    for (int i = 0; i < 40; i++) begin
      if1.wen = 1'b1; if1.ren = 1'b1; if1.wdata = 8'(8'hC0 + i);
      cyc();
      vecs++; if (if1.full !== 1'b1) begin errs++; $display("FAIL fwft_wrap_full cycle %0d: got %b", i, if1.full); end
    end
    if1.wen = 1'b0;
    repeat (32) cyc();
    if1.ren = 1'b0;
    cyc();
    vecs++; if (q1.size() != 0) begin errs++; $display("FAIL fwft_wrap_all: %0d words left, want 0", q1.size()); end
    vecs++; if (if1.rdata !== 8'hE7) begin errs++; $display("FAIL fwft_wrap_last: got %02h want e7", if1.rdata); end
  endtask
  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      if0.wen = 1'b1; if0.wdata = 8'(8'h70 + i);
      cyc();
    end
    if0.wen = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (if0.count !== 6'd0) begin errs++; $display("FAIL arst_count: got %0d want 0", if0.count); end
    vecs++; if (if0.empty !== 1'b1) begin errs++; $display("FAIL arst_empty: got %b want 1", if0.empty); end
    vecs++; if (if0.rdata !== 8'h00) begin errs++; $display("FAIL arst_rdata: got %02h want 00", if0.rdata); end
    cyc();
    rst_n = 1'b1;
    cyc();
    if0.wen = 1'b1; if0.wdata = 8'h77;
    cyc();
    if0.wen = 1'b0; if0.ren = 1'b1;
    cyc();
    if0.ren = 1'b0;
    repeat (2) cyc();
    vecs++; if (if0.rdata !== 8'h77) begin errs++; $display("FAIL arst_reuse: rdata=%02h want 77", if0.rdata); end
  endtask
  initial begin
    idle();
    test_reset();
    test_fill_overflow();
    test_std_latency();
    test_wrap();
    test_clr();
    test_fwft();
    test_fwft_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
